div_shift_sub: RTL

//  Parametrised sequential restoring divider (shift-and-subtract), radix-2.

---
 rtl/div_shift_sub_pkg.sv | 22 ++
 rtl/div_shift_sub_if.sv | 27 ++
 rtl/div_shift_sub_ctrl.sv | 97 +++++++++
 rtl/div_shift_sub.sv | 112 +++++++++++
 4 files changed

// File: rtl/div_shift_sub_pkg.sv
// Shared types for the shift-and-subtract divider: FSM state encoding and the
// divide-by-zero quotient constant.
package div_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // All-ones pattern of the requested width, returned right-aligned.
  function automatic logic [MAX_W-1:0] dz_quotient(input int width);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return (width >= MAX_W) ? ones : (ones >> (MAX_W - width));
  endfunction

endpackage

// File: rtl/div_shift_sub_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// DIV_SIGNED_EN adds the signed_mode request qualifier.
interface div_shift_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;
`ifdef DIV_SIGNED_EN
    logic             signed_mode;

    modport master(output start, dividend, divisor, signed_mode,
                   input  quotient, remainder, busy, done, div_zero);
    modport slave (input  start, dividend, divisor, signed_mode,
                   output quotient, remainder, busy, done, div_zero);
`else
    modport master(output start, dividend, divisor,
                   input  quotient, remainder, busy, done, div_zero);
    modport slave (input  start, dividend, divisor,
                   output quotient, remainder, busy, done, div_zero);
`endif
endinterface

// File: rtl/div_shift_sub_ctrl.sv
// Divider sequencer: IDLE -> LOAD -> ITER x WIDTH -> [SIGN] -> DONE, plus the
// iteration counter. SIGN exists only when DIV_SIGNED_EN is defined.
module div_shift_sub_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    input  logic i_dvs_zero,
    output logic o_accept,
    output logic o_load,
    output logic o_shift,
`ifdef DIV_SIGNED_EN
    output logic o_fix,
`endif
    output logic o_finish,
    output logic o_done,
    output logic o_busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(1));
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (o_load && !i_dvs_zero) begin
                r_cnt <= CNT_W'(WIDTH);
            end else if (o_shift) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_next   = r_state;
        o_accept = 1'b0;
        o_load   = 1'b0;
        o_shift  = 1'b0;
`ifdef DIV_SIGNED_EN
        o_fix    = 1'b0;
`endif
        o_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    o_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                o_load = 1'b1;
                if (i_dvs_zero) begin
                    o_finish = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_ITER: begin
                o_shift = 1'b1;
                if (w_last) begin
`ifdef DIV_SIGNED_EN
                    w_next   = S_SIGN;
`else
                    o_finish = 1'b1;
                    w_next   = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_SIGN: begin
                o_fix    = 1'b1;
                o_finish = 1'b1;
                w_next   = S_DONE;
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/div_shift_sub.sv
// Radix-2 restoring divider, one quotient bit per cycle. Define DIV_SIGNED_EN
// for two's-complement operation (truncation toward zero) via an extra SIGN step.
module div_shift_sub
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    div_shift_sub_if.slave bus
);
    localparam logic [WIDTH-1:0] DZ_QUO = WIDTH'(dz_quotient(WIDTH));

    logic             w_accept, w_load, w_shift, w_finish, w_dvs_zero;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_quo, r_rem;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_div_zero;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_rem_next, w_quo_next;
    logic [WIDTH:0]   w_r_shift, w_trial;

`ifdef DIV_SIGNED_EN
    logic w_fix, w_dvd_neg, w_dvs_neg, r_neg_q, r_neg_r;

    assign w_dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? (WIDTH'(0) - bus.divisor) : bus.divisor;
`else
    assign w_dvd_mag = bus.dividend;
    assign w_dvs_mag = bus.divisor;
`endif

    div_shift_sub_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (bus.start),
        .i_dvs_zero(w_dvs_zero),
        .o_accept  (w_accept),
        .o_load    (w_load),
        .o_shift   (w_shift),
`ifdef DIV_SIGNED_EN
        .o_fix     (w_fix),
`endif
        .o_finish  (w_finish),
        .o_done    (bus.done),
        .o_busy    (bus.busy)
    );

    // The partial remainder stays below the divisor between steps, so only its
    // low WIDTH bits are stored; the shifted value regains the extra bit.
    assign w_dvs_zero = (r_dvs == '0);
    assign w_r_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_r_shift - {1'b0, r_dvs};
    assign w_rem_next = w_trial[WIDTH] ? w_r_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_dvd <= bus.dividend;
                r_dvs <= w_dvs_mag;
                r_quo <= w_dvd_mag;
`ifdef DIV_SIGNED_EN
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
`endif
            end
            if (w_load) begin
                r_rem <= '0;
            end
            if (w_shift) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end
            if (w_finish && w_load) begin
                r_quotient  <= DZ_QUO;
                r_remainder <= r_dvd;
                r_div_zero  <= 1'b1;
            end
`ifdef DIV_SIGNED_EN
            if (w_fix) begin
                r_quotient  <= r_neg_q ? (WIDTH'(0) - r_quo) : r_quo;
                r_remainder <= r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;
                r_div_zero  <= 1'b0;
            end
`else
            if (w_finish && w_shift) begin
                r_quotient  <= w_quo_next;
                r_remainder <= w_rem_next;
                r_div_zero  <= 1'b0;
            end
`endif
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;

endmodule
